mvu_pe_simd_acc: RTL and testbench



---
 rtl/mvu_pe_simd_acc.sv | 202 ++++++++++++++++++++
 tb/tb_mvu_pe_simd_acc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mvu_pe_simd_acc.sv
// mvu_pe_simd_acc: pipelined SIMD multiply-accumulate PE for the MVU stream.
// Lane products (stage 1) -> adder tree (stage 2) -> fold accumulator (stage 3)
// -> output register (stage 4). A single stall enable freezes the whole pipe
// while a result waits for the consumer.
// Optional build macro: MVU_PE_SAT_EN makes the lane sum and the accumulation
// saturate instead of wrapping modulo 2^TDstI.
module mvu_pe_simd_acc #(
    parameter int         SIMD   = 4,
    parameter int         TSrcI  = 4,
    parameter int         TW     = 4,
    parameter int         TDstI  = 16,
    parameter logic [1:0] OP_SGN = 2'b00,
    parameter int         SF     = 8
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIMD*TSrcI-1:0] in_act,
    input  logic [SIMD*TW-1:0]    in_wgt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TDstI-1:0]      out_data
);

    localparam bit A_SGN = OP_SGN[1];
    localparam bit W_SGN = OP_SGN[0];
`ifdef MVU_PE_SAT_EN
    // Products and the lane sum are kept wide enough that clamping sees the
    // true value rather than an already-wrapped one.
    localparam int PW      = TSrcI + TW + 2;
    localparam int PRW     = (PW > TDstI) ? PW : TDstI;
    localparam int SW      = PRW + $clog2(SIMD) + 2;
    localparam bit UNS_DOM = (OP_SGN == 2'b00);
    localparam logic signed [SW-1:0] U_MAX = {{(SW-TDstI){1'b0}}, {TDstI{1'b1}}};
    localparam logic signed [SW-1:0] S_MAX = {{(SW-TDstI+1){1'b0}}, {(TDstI-1){1'b1}}};
    localparam logic signed [SW-1:0] S_MIN = {{(SW-TDstI+1){1'b1}}, {(TDstI-1){1'b0}}};
`else
    // Wrapping arithmetic only needs the low TDstI bits everywhere.
    localparam int PRW = TDstI;
    localparam int SW  = TDstI;
`endif
    localparam int CW = (SF > 1) ? $clog2(SF) : 1;
    localparam logic signed [PRW-1:0] P_ONE  = {{(PRW-1){1'b0}}, 1'b1};
    localparam logic signed [PRW-1:0] P_MONE = {PRW{1'b1}};

    logic                  en;
    logic                  init_q;
    logic signed [PRW-1:0] prod_d [SIMD];
    logic signed [PRW-1:0] prod_q [SIMD];
    logic                  s1_valid_q;
    logic signed [SW-1:0]  sum_full;
    logic [TDstI-1:0]      sum_d;
    logic [TDstI-1:0]      sum_q;
    logic                  s2_valid_q;
    logic [TDstI-1:0]      acc_d;
    logic [TDstI-1:0]      acc_q;
    logic [CW-1:0]         fold_cnt_q;
    logic                  fold_last;
    logic                  acc_done_q;
    logic                  out_valid_q;
    logic [TDstI-1:0]      out_data_q;

`ifdef MVU_PE_SAT_EN
    function automatic logic [TDstI-1:0] sat_fn(input logic signed [SW-1:0] v);
        if (UNS_DOM) begin
            if (v[SW-1]) return '0;
            if (v > U_MAX) return U_MAX[TDstI-1:0];
            return v[TDstI-1:0];
        end
        if (v > S_MAX) return S_MAX[TDstI-1:0];
        if (v < S_MIN) return S_MIN[TDstI-1:0];
        return v[TDstI-1:0];
    endfunction

    function automatic logic signed [SW-1:0] ext_fn(input logic [TDstI-1:0] v);
        if (UNS_DOM) return {{(SW-TDstI){1'b0}}, v};
        return {{(SW-TDstI){v[TDstI-1]}}, v};
    endfunction
`endif

    assign en       = !out_valid_q | out_ready;
    assign in_ready = en & init_q;

    // Per-lane product; the encoding depends only on operand widths and OP_SGN.
    for (genvar i = 0; i < SIMD; i++) begin : g_lane
        logic [TSrcI-1:0] a;
        logic [TW-1:0]    w;
        assign a = in_act[i*TSrcI +: TSrcI];
        assign w = in_wgt[i*TW +: TW];

        if (TSrcI == 1 && TW == 1) begin : g_bb
            if (A_SGN && W_SGN) begin : g_pp
                assign prod_d[i] = (a[0] == w[0]) ? P_ONE : P_MONE;
            end else if (A_SGN) begin : g_pz
                assign prod_d[i] = w[0] ? (a[0] ? P_ONE : P_MONE) : '0;
            end else if (W_SGN) begin : g_zp
                assign prod_d[i] = a[0] ? (w[0] ? P_ONE : P_MONE) : '0;
            end else begin : g_zz
                assign prod_d[i] = (a[0] & w[0]) ? P_ONE : '0;
            end
        end else if (TSrcI == 1) begin : g_bn
            logic signed [PRW-1:0] w_e;
            assign w_e       = {{(PRW-TW){W_SGN ? w[TW-1] : 1'b0}}, w};
            assign prod_d[i] = a[0] ? w_e : (A_SGN ? -w_e : '0);
        end else if (TW == 1) begin : g_nb
            logic signed [PRW-1:0] a_e;
            assign a_e       = {{(PRW-TSrcI){A_SGN ? a[TSrcI-1] : 1'b0}}, a};
            assign prod_d[i] = w[0] ? a_e : (W_SGN ? -a_e : '0);
        end else begin : g_nn
            logic signed [PRW-1:0] a_e;
            logic signed [PRW-1:0] w_e;
            assign a_e       = {{(PRW-TSrcI){A_SGN ? a[TSrcI-1] : 1'b0}}, a};
            assign w_e       = {{(PRW-TW){W_SGN ? w[TW-1] : 1'b0}}, w};
            assign prod_d[i] = a_e * w_e;
        end
    end

    // Input acceptance is held off until the first cycle after reset.
    always_ff @(posedge aclk) begin
        if (rst) init_q <= 1'b0;
        else     init_q <= 1'b1;
    end

    // Stage 1: register lane products of an accepted beat.
    always_ff @(posedge aclk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            for (int i = 0; i < SIMD; i++) prod_q[i] <= '0;
        end else if (en) begin
            s1_valid_q <= in_valid & in_ready;
            prod_q     <= prod_d;
        end
    end

    // Adder tree over all lanes.
    always_comb begin
        sum_full = '0;
        for (int i = 0; i < SIMD; i++) sum_full = sum_full + SW'(prod_q[i]);
`ifdef MVU_PE_SAT_EN
        sum_d = sat_fn(sum_full);
`else
        sum_d = sum_full;
`endif
    end

    // Stage 2: register the lane sum.
    always_ff @(posedge aclk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
        end else if (en) begin
            s2_valid_q <= s1_valid_q;
            sum_q      <= sum_d;
        end
    end

    assign fold_last = (fold_cnt_q == CW'(SF - 1));

    // First beat of a fold overwrites the accumulator, later beats add to it.
    always_comb begin
        if (fold_cnt_q == '0) begin
            acc_d = sum_q;
        end else begin
`ifdef MVU_PE_SAT_EN
            acc_d = sat_fn(ext_fn(acc_q) + ext_fn(sum_q));
`else
            acc_d = acc_q + sum_q;
`endif
        end
    end

    // Stage 3: fold accumulator; bubbles leave the count untouched.
    always_ff @(posedge aclk) begin
        if (rst) begin
            acc_q      <= '0;
            fold_cnt_q <= '0;
            acc_done_q <= 1'b0;
        end else if (en) begin
            acc_done_q <= s2_valid_q & fold_last;
            if (s2_valid_q) begin
                acc_q      <= acc_d;
                fold_cnt_q <= fold_last ? '0 : fold_cnt_q + 1'b1;
            end
        end
    end

    // Stage 4: output register; a consumed result is replaced or retired.
    always_ff @(posedge aclk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (en) begin
            out_valid_q <= acc_done_q;
            if (acc_done_q) out_data_q <= acc_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mvu_pe_simd_acc.sv
// Directed bench for mvu_pe_simd_acc using several parameterisations side by side.
module tb_mvu_pe_simd_acc;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic rst;
    logic rst3;
    int   total  = 0;
    int   passed = 0;

`ifdef MVU_PE_SAT_EN
    localparam logic [7:0] OVF_EXP = 8'd255;
`else
    localparam logic [7:0] OVF_EXP = 8'd8;
`endif

    // u0: unsigned 4x4, SF=2
    logic v0, r0, ov0, or0;
    logic [15:0] a0, w0, od0;
    // u1: signed 4x4, SF=2
    logic v1, r1, ov1, or1;
    logic [15:0] a1, w1, od1;
    // u2: binary +/-1, SF=1
    logic v2, r2, ov2, or2;
    logic [3:0] a2, w2;
    logic [15:0] od2;
    // u3: unsigned, SF=4, private reset pulse
    logic v3, r3, ov3, or3;
    logic [15:0] a3, w3, od3;
    // u4: unsigned, 8-bit result, SF=2
    logic v4, r4, ov4, or4;
    logic [15:0] a4, w4;
    logic [7:0] od4;

    mvu_pe_simd_acc #(.SIMD(4), .TSrcI(4), .TW(4), .TDstI(16), .OP_SGN(2'b00), .SF(2)) u0 (
        .aclk(aclk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_act(a0), .in_wgt(w0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0));
    mvu_pe_simd_acc #(.SIMD(4), .TSrcI(4), .TW(4), .TDstI(16), .OP_SGN(2'b11), .SF(2)) u1 (
        .aclk(aclk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_act(a1), .in_wgt(w1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1));
    mvu_pe_simd_acc #(.SIMD(4), .TSrcI(1), .TW(1), .TDstI(16), .OP_SGN(2'b11), .SF(1)) u2 (
        .aclk(aclk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_act(a2), .in_wgt(w2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2));
    mvu_pe_simd_acc #(.SIMD(4), .TSrcI(4), .TW(4), .TDstI(16), .OP_SGN(2'b00), .SF(4)) u3 (
        .aclk(aclk), .rst(rst | rst3), .in_valid(v3), .in_ready(r3), .in_act(a3), .in_wgt(w3),
        .out_valid(ov3), .out_ready(or3), .out_data(od3));
    mvu_pe_simd_acc #(.SIMD(4), .TSrcI(4), .TW(4), .TDstI(8), .OP_SGN(2'b00), .SF(2)) u4 (
        .aclk(aclk), .rst(rst), .in_valid(v4), .in_ready(r4), .in_act(a4), .in_wgt(w4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4));

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst3 = 1'b0;
        v0 = 0; v1 = 0; v2 = 0; v3 = 0; v4 = 0;
        or0 = 1; or1 = 1; or2 = 1; or3 = 1; or4 = 1;
        a0 = '0; w0 = '0; a1 = '0; w1 = '0; a2 = '0; w2 = '0;
        a3 = '0; w3 = '0; a4 = '0; w4 = '0;
        repeat (3) tick();
        total++; if (ov0 !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", ov0); else passed++;
        total++; if (od0 !== 16'd0) $display("FAIL reset_out_data: got %0d expected 0", od0); else passed++;
        total++; if (r0 !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", r0); else passed++;
        total++; if (ov3 !== 1'b0) $display("FAIL reset_out_valid_u3: got %b expected 0", ov3); else passed++;
        total++; if (od4 !== 8'd0) $display("FAIL reset_out_data_u4: got %0d expected 0", od4); else passed++;
        rst = 1'b0;
        tick();
        total++;
        if ({r0, r1, r2, r3, r4} !== 5'b11111)
            $display("FAIL in_ready_after_reset: got %b expected 11111", {r0, r1, r2, r3, r4});
        else passed++;
    endtask

    task automatic test_unsigned_full_scale();
        a0 = 16'hFFFF; w0 = 16'hFFFF; v0 = 1;
        tick(); tick();
        v0 = 0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++;
            if (ov0 !== (k == 3)) $display("FAIL uns_latency_c%0d: got %b expected %b", k, ov0, (k == 3));
            else passed++;
        end
        total++; if (od0 !== 16'd1800) $display("FAIL uns_full_scale: got %0d expected 1800", od0); else passed++;
        tick();
        total++; if (ov0 !== 1'b0) $display("FAIL uns_valid_retire: got %b expected 0", ov0); else passed++;
    endtask

    task automatic test_signed();
        for (int i = 0; i < 4; i++) begin
            a1 = 16'h8888;
            w1 = (i < 2) ? 16'h8888 : 16'h7777;
            v1 = 1;
            tick();
        end
        v1 = 0;
        tick();
        total++; if (ov1 !== 1'b1) $display("FAIL sgn_valid_a: got %b expected 1", ov1); else passed++;
        total++; if (od1 !== 16'd512) $display("FAIL sgn_neg_neg: got %0d expected 512", od1); else passed++;
        tick();
        total++; if (ov1 !== 1'b0) $display("FAIL sgn_gap: got %b expected 0", ov1); else passed++;
        tick();
        total++; if (ov1 !== 1'b1) $display("FAIL sgn_valid_b: got %b expected 1", ov1); else passed++;
        total++; if (od1 !== 16'hFE40) $display("FAIL sgn_neg_pos: got %h expected fe40", od1); else passed++;
    endtask

    task automatic test_binary();
        a2 = 4'b1010; w2 = 4'b1100; v2 = 1;
        tick();
        a2 = 4'b0110; w2 = 4'b0110;
        tick();
        v2 = 0;
        tick();
        total++; if (ov2 !== 1'b0) $display("FAIL bin_early: got %b expected 0", ov2); else passed++;
        tick();
        total++; if (ov2 !== 1'b1) $display("FAIL bin_valid_a: got %b expected 1", ov2); else passed++;
        total++; if (od2 !== 16'd0) $display("FAIL bin_mixed: got %0d expected 0", od2); else passed++;
        tick();
        total++; if (ov2 !== 1'b1) $display("FAIL bin_valid_b: got %b expected 1", ov2); else passed++;
        total++; if (od2 !== 16'd4) $display("FAIL bin_equal: got %0d expected 4", od2); else passed++;
    endtask

    task automatic test_bubbles();
        a0 = 16'h2222; w0 = 16'h3333;
        v0 = 1; tick();
        v0 = 0; tick();
        v0 = 1; tick();
        v0 = 0;
        tick(); tick();
        total++; if (ov0 !== 1'b0) $display("FAIL bubble_no_advance: got %b expected 0", ov0); else passed++;
        tick();
        total++; if (od0 !== 16'd48 || ov0 !== 1'b1)
            $display("FAIL bubble_result: got %0d/%b expected 48/1", od0, ov0);
        else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        or0 = 0;
        for (int i = 0; i < 4; i++) begin
            a0 = (i < 2) ? 16'h1111 : 16'h3333;
            w0 = (i < 2) ? 16'h2222 : 16'h1111;
            v0 = 1;
            tick();
        end
        v0 = 0;
        tick();
        total++; if (ov0 !== 1'b1) $display("FAIL bp_valid: got %b expected 1", ov0); else passed++;
        total++; if (od0 !== 16'd16) $display("FAIL bp_fold_a: got %0d expected 16", od0); else passed++;
        total++; if (r0 !== 1'b0) $display("FAIL bp_in_ready_drop: got %b expected 0", r0); else passed++;
        a0 = 16'h2222; w0 = 16'h2222; v0 = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (od0 !== 16'd16 || ov0 !== 1'b1)
                $display("FAIL bp_hold_c%0d: got %0d/%b expected 16/1", k, od0, ov0);
            else passed++;
            total++; if (r0 !== 1'b0) $display("FAIL bp_ready_hold_c%0d: got %b expected 0", k, r0); else passed++;
        end
        or0 = 1;
        #1;
        total++; if (r0 !== 1'b1) $display("FAIL bp_ready_release: got %b expected 1", r0); else passed++;
        tick();
        total++; if (ov0 !== 1'b0) $display("FAIL bp_retire: got %b expected 0", ov0); else passed++;
        tick();
        v0 = 0;
        total++; if (ov0 !== 1'b1) $display("FAIL bp_valid_b: got %b expected 1", ov0); else passed++;
        total++; if (od0 !== 16'd24) $display("FAIL bp_fold_b: got %0d expected 24", od0); else passed++;
        repeat (3) tick();
        total++; if (ov0 !== 1'b1) $display("FAIL bp_valid_c: got %b expected 1", ov0); else passed++;
        total++; if (od0 !== 16'd32) $display("FAIL bp_fold_c: got %0d expected 32", od0); else passed++;
        tick();
    endtask

    task automatic test_reset_mid_fold();
        a3 = 16'h1111; w3 = 16'h1111; v3 = 1;
        repeat (4) tick();
        v3 = 0;
        repeat (3) tick();
        total++; if (od3 !== 16'd16 || ov3 !== 1'b1)
            $display("FAIL rmf_first_fold: got %0d/%b expected 16/1", od3, ov3);
        else passed++;
        a3 = 16'h3333; w3 = 16'h3333; v3 = 1;
        tick(); tick();
        v3 = 0; rst3 = 1;
        tick();
        rst3 = 0;
        total++; if (ov3 !== 1'b0) $display("FAIL rmf_out_valid: got %b expected 0", ov3); else passed++;
        total++; if (od3 !== 16'd0) $display("FAIL rmf_out_data: got %0d expected 0", od3); else passed++;
        total++; if (r3 !== 1'b0) $display("FAIL rmf_in_ready_low: got %b expected 0", r3); else passed++;
        tick();
        total++; if (r3 !== 1'b1) $display("FAIL rmf_in_ready_high: got %b expected 1", r3); else passed++;
        a3 = 16'h1111; w3 = 16'h1111; v3 = 1;
        repeat (4) tick();
        v3 = 0;
        repeat (2) tick();
        total++; if (ov3 !== 1'b0) $display("FAIL rmf_no_early: got %b expected 0", ov3); else passed++;
        tick();
        total++; if (ov3 !== 1'b1) $display("FAIL rmf_valid: got %b expected 1", ov3); else passed++;
        total++; if (od3 !== 16'd16) $display("FAIL rmf_new_fold: got %0d expected 16", od3); else passed++;
    endtask

    task automatic test_overflow();
        a4 = 16'hFFFF; w4 = 16'hFFFF; v4 = 1;
        tick(); tick();
        v4 = 0;
        repeat (3) tick();
        total++; if (ov4 !== 1'b1) $display("FAIL ovf_valid: got %b expected 1", ov4); else passed++;
        total++; if (od4 !== OVF_EXP) $display("FAIL ovf_result: got %0d expected %0d", od4, OVF_EXP); else passed++;
    endtask

    initial begin
        test_reset();
        test_unsigned_full_scale();
        test_signed();
        test_binary();
        test_bubbles();
        test_backpressure();
        test_reset_mid_fold();
        test_overflow();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
